// File: rtl/iir_df_i_tdm.sv
// iir_df_i_tdm: time-multiplexed direct-form-I IIR filter sharing one MAC across channels
module iir_df_i_tdm #(
  parameter int N = 2,
  parameter int CHANNELS = 4,
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 12,
  parameter int COEFF_WIDTH = 16,
  parameter int Q = 14,
  parameter int ACC_WIDTH = 40,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_ch,
  input  logic signed [X_WIDTH-1:0]    x,
  input  logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
  input  logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
  input  logic                         clear_state,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [Y_WIDTH-1:0]    y,
  output logic                         sat
);
  localparam int KW = $clog2(2*N+1);
  localparam int DW = X_WIDTH > Y_WIDTH ? X_WIDTH : Y_WIDTH;
  localparam int PW = DW + COEFF_WIDTH;
  localparam int XHW = N * X_WIDTH;
  localparam int YHW = N * Y_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (Q - 1);
  localparam logic signed [ACC_WIDTH-1:0] YMAX = (ACC_WIDTH'(1) <<< (Y_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] YMIN = -YMAX - 1;
  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q;
  logic [CH_W-1:0] ch_q, out_ch_q;
  logic signed [X_WIDTH-1:0] x_q;
  logic [COEFF_WIDTH*(N+1)-1:0] b_q;
  logic [COEFF_WIDTH*N-1:0] a_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, rnd;
  logic [XHW-1:0] xh_q [CHANNELS];
  logic [YHW-1:0] yh_q [CHANNELS];
  logic [XHW-1:0] xs;
  logic [YHW-1:0] ys;
  logic signed [Y_WIDTH-1:0] y_q, y_sat;
  logic sat_q, sat_d, sub, accept;
  logic signed [DW-1:0] op;
  logic signed [COEFF_WIDTH-1:0] coef;
  logic signed [PW-1:0] prod;
  assign accept = in_valid && in_ready;
  assign y = y_q;
  assign sat = sat_q;
  assign out_ch = out_ch_q;
  // state register
  always_ff @(posedge clk) state_q <= !rst_n ? IDLE : state_d;
  // next state: out-of-range channels are accepted and silently dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept && int'(in_ch) < CHANNELS ? MAC : IDLE;
      MAC:     state_d = k_q == KW'(2*N) ? ROUND : MAC;
      ROUND:   state_d = OUT;
      OUT:     state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  // handshake outputs
  always_comb begin
    in_ready = rst_n && state_q == IDLE && !clear_state;
    out_valid = state_q == OUT;
  end
  // term k: 0 is b0*x, 1..N are b*x history, N+1..2N are a*y history (subtracted)
  always_comb begin
    xs = xh_q[ch_q];
    ys = yh_q[ch_q];
    op = DW'(x_q);
    coef = $signed(b_q[COEFF_WIDTH-1:0]);
    sub = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (k_q == KW'(j + 1)) begin
        op = DW'($signed(xs[X_WIDTH*j +: X_WIDTH]));
        coef = $signed(b_q[COEFF_WIDTH*(j+1) +: COEFF_WIDTH]);
      end
      if (k_q == KW'(N + 1 + j)) begin
        op = DW'($signed(ys[Y_WIDTH*j +: Y_WIDTH]));
        coef = $signed(a_q[COEFF_WIDTH*j +: COEFF_WIDTH]);
        sub = 1'b1;
      end
    end
    prod = PW'(op) * PW'(coef);
    acc_d = sub ? acc_q - ACC_WIDTH'(prod) : acc_q + ACC_WIDTH'(prod);
  end
  // round half up, then clamp to the output range
  always_comb begin
    rnd = (acc_q + HALF) >>> Q;
    sat_d = rnd > YMAX || rnd < YMIN;
    y_sat = rnd > YMAX ? YMAX[Y_WIDTH-1:0] : rnd < YMIN ? YMIN[Y_WIDTH-1:0] : rnd[Y_WIDTH-1:0];
  end
  // latch the accepted sample, run the MAC, capture the rounded result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q <= '0;
      ch_q <= '0;
      x_q <= '0;
      b_q <= '0;
      a_q <= '0;
      acc_q <= '0;
      y_q <= '0;
      out_ch_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (accept) begin
        k_q <= '0;
        ch_q <= in_ch;
        x_q <= x;
        b_q <= packed_b_coeffs;
        a_q <= packed_a_coeffs;
        acc_q <= '0;
      end
      if (state_q == MAC) begin
        k_q <= k_q + 1'b1;
        acc_q <= acc_d;
      end
      if (state_q == ROUND) begin
        y_q <= y_sat;
        sat_q <= sat_d;
        out_ch_q <= ch_q;
      end
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_hist
    // shift the committed x and saturated y into this channel's history, or wipe it
    always_ff @(posedge clk)
      if (!rst_n || (state_q == IDLE && clear_state)) begin
        xh_q[c] <= '0;
        yh_q[c] <= '0;
      end else if (state_q == ROUND && ch_q == CH_W'(c)) begin
        xh_q[c] <= XHW'({xh_q[c], x_q});
        yh_q[c] <= YHW'({yh_q[c], y_sat});
      end
  end
endmodule

// File: tb/tb_iir_df_i_tdm.sv
// tb_iir_df_i_tdm: directed and randomized checks of iir_df_i_tdm against a difference-equation model
module tb_iir_df_i_tdm;
  localparam int N = 2, CH = 3, XW = 12, YW = 12, CW = 16, Q = 14, AW = 40;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clear_state = 0;
  logic in_ready, out_valid, sat;
  logic [1:0] in_ch = 0, out_ch;
  logic signed [XW-1:0] x = 0;
  logic signed [YW-1:0] y;
  logic [CW*(N+1)-1:0] pb;
  logic [CW*N-1:0] pa;
  int b_c [N+1];
  int a_c [N+1];
  int mxh [CH][N];
  int myh [CH][N];
  int m_y;
  bit m_sat;
  int passed = 0, total = 0;

  iir_df_i_tdm #(.N(N), .CHANNELS(CH), .X_WIDTH(XW), .Y_WIDTH(YW), .COEFF_WIDTH(CW), .Q(Q), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .x(x),
    .packed_b_coeffs(pb), .packed_a_coeffs(pa), .clear_state(clear_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .y(y), .sat(sat));

  always #5 clk = ~clk;

  always_comb begin
    pb = '0;
    pa = '0;
    for (int k = 0; k <= N; k++) pb[CW*k +: CW] = CW'(b_c[k]);
    for (int k = 1; k <= N; k++) pa[CW*(k-1) +: CW] = CW'(a_c[k]);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  // y[n] = sat(round((sum b*x - sum a*y) / 2^Q)) per channel
  task automatic model_step(input int ch, input int xv);
    longint s = longint'(b_c[0]) * xv;
    for (int k = 1; k <= N; k++)
      s += longint'(b_c[k]) * mxh[ch][k-1] - longint'(a_c[k]) * myh[ch][k-1];
    s = (s + (longint'(1) << (Q - 1))) >>> Q;
    m_sat = s > 2047 || s < -2048;
    m_y = s > 2047 ? 2047 : s < -2048 ? -2048 : int'(s);
    for (int k = N - 1; k > 0; k--) begin
      mxh[ch][k] = mxh[ch][k-1];
      myh[ch][k] = myh[ch][k-1];
    end
    mxh[ch][0] = xv;
    myh[ch][0] = m_y;
  endtask

  task automatic model_clear;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < N; k++) begin
        mxh[c][k] = 0;
        myh[c][k] = 0;
      end
  endtask

  task automatic set_coeffs(input int b0, input int b1, input int b2, input int a1, input int a2);
    b_c[0] = b0; b_c[1] = b1; b_c[2] = b2; a_c[0] = 0; a_c[1] = a1; a_c[2] = a2;
  endtask

  // offer one sample, scramble x and coefficients after acceptance, wait for out_valid (out_ready held low)
  task automatic send(input int ch, input int xv, output bit got, output int yv, output bit sv, output int chv, output int lat);
    int sb [N+1];
    int sa [N+1];
    in_valid = 1; in_ch = 2'(ch); x = XW'(xv);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    if (ch < CH) model_step(ch, xv);
    sb = b_c; sa = a_c;
    @(negedge clk);
    in_valid = 0; x = XW'($urandom);
    for (int k = 0; k <= N; k++) begin
      b_c[k] = int'($urandom_range(65535)) - 32768;
      a_c[k] = int'($urandom_range(65535)) - 32768;
    end
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    b_c = sb; a_c = sa;
    got = out_valid; yv = int'(y); sv = sat; chv = int'(out_ch);
  endtask

  task automatic finish_out;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic pulse_clear;
    clear_state = 1;
    @(negedge clk);
    clear_state = 0;
    model_clear();
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got %0b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    total++; if (y !== 12'sd0 || sat !== 1'b0 || out_ch !== 2'd0) $display("FAIL reset_outputs got y=%0d sat=%0b ch=%0d want 0 0 0", y, sat, out_ch); else passed++;
    rst_n = 1;
    model_clear();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %0b want 1", in_ready); else passed++;
  endtask

  task automatic test_identity;
    bit got, sv; int yv, chv, lat;
    set_coeffs(16384, 0, 0, 0, 0);
    send(0, 100, got, yv, sv, chv, lat);
    total++; if (lat !== 7 || !got) $display("FAIL identity_latency got %0d want 7", lat); else passed++;
    total++; if (yv !== 100 || yv !== m_y) $display("FAIL identity_y got %0d want 100", yv); else passed++;
    total++; if (sv !== 1'b0 || chv !== 0) $display("FAIL identity_sat_ch got sat=%0b ch=%0d want 0 0", sv, chv); else passed++;
    finish_out();
  endtask

  task automatic test_feedback;
    int xs [3] = '{1000, 0, 0};
    int es [3] = '{1000, 500, 250};
    bit got, sv; int yv, chv, lat;
    set_coeffs(16384, 0, 0, -8192, 0);
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      send(0, xs[i], got, yv, sv, chv, lat);
      total++; if (!got || yv !== es[i] || yv !== m_y) $display("FAIL feedback_y%0d got %0d want %0d", i, yv, es[i]); else passed++;
      finish_out();
    end
  endtask

  task automatic test_rounding;
    int xs [2] = '{3, -3};
    int es [2] = '{2, -1};
    bit got, sv; int yv, chv, lat;
    set_coeffs(8192, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      send(1, xs[i], got, yv, sv, chv, lat);
      total++; if (!got || yv !== es[i] || yv !== m_y || sv !== 1'b0) $display("FAIL rounding_x%0d got %0d sat=%0b want %0d sat=0", xs[i], yv, sv, es[i]); else passed++;
      finish_out();
    end
  endtask

  task automatic test_saturation;
    int xs [2] = '{2047, -2048};
    int es [2] = '{2047, -2048};
    bit got, sv; int yv, chv, lat;
    set_coeffs(32767, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      send(2, xs[i], got, yv, sv, chv, lat);
      total++; if (!got || yv !== es[i] || yv !== m_y) $display("FAIL saturation_y%0d got %0d want %0d", i, yv, es[i]); else passed++;
      total++; if (sv !== 1'b1 || chv !== 2) $display("FAIL saturation_flag%0d got sat=%0b ch=%0d want 1 2", i, sv, chv); else passed++;
      finish_out();
    end
  endtask

  task automatic test_backpressure;
    int cs [5] = '{0, 1, 0, 1, 0};
    int xs [5] = '{1000, 0, 0, 0, 0};
    int es [5] = '{1000, 0, 500, 0, 250};
    bit got, sv, stable; int yv, chv, lat;
    set_coeffs(16384, 0, 0, -8192, 0);
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      send(cs[i], xs[i], got, yv, sv, chv, lat);
      total++; if (!got || yv !== es[i] || yv !== m_y || chv !== cs[i]) $display("FAIL backpressure_y%0d got %0d ch=%0d want %0d ch=%0d", i, yv, chv, es[i], cs[i]); else passed++;
      stable = 1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (int'(y) != yv || int'(out_ch) != chv || sat != sv || !out_valid || in_ready) stable = 0;
      end
      total++; if (!stable) $display("FAIL backpressure_hold%0d got unstable want stable y=%0d", i, yv); else passed++;
      finish_out();
    end
  endtask

  task automatic test_clear;
    bit got, sv; int yv, chv, lat;
    set_coeffs(16384, 0, 0, -8192, 0);
    send(2, 1000, got, yv, sv, chv, lat);
    total++; if (!got || yv !== m_y) $display("FAIL clear_prime got %0d want %0d", yv, m_y); else passed++;
    finish_out();
    in_valid = 1; in_ch = 2; x = 55; clear_state = 1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL clear_blocks_ready got %0b want 0", in_ready); else passed++;
    @(negedge clk);
    in_valid = 0; clear_state = 0;
    model_clear();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL clear_no_accept got ov=%0b rdy=%0b want 0 1", out_valid, in_ready); else passed++;
    send(2, 0, got, yv, sv, chv, lat);
    total++; if (!got || yv !== 0 || yv !== m_y) $display("FAIL clear_restart got %0d want 0", yv); else passed++;
    finish_out();
  endtask

  task automatic test_bad_channel;
    bit got, sv; int yv, chv, lat, seen;
    set_coeffs(16384, 0, 0, -8192, 0);
    pulse_clear();
    send(0, 1000, got, yv, sv, chv, lat);
    finish_out();
    in_valid = 1; in_ch = 2'(CH); x = 777;
    @(negedge clk);
    in_valid = 0;
    total++; if (in_ready !== 1'b1) $display("FAIL badch_return_idle got %0b want 1", in_ready); else passed++;
    seen = 0;
    for (int i = 0; i < 2*N + 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL badch_no_output got %0d valid cycles want 0", seen); else passed++;
    send(0, 0, got, yv, sv, chv, lat);
    total++; if (!got || yv !== 500 || yv !== m_y) $display("FAIL badch_history_kept got %0d want 500", yv); else passed++;
    finish_out();
  endtask

  task automatic test_reset_mid_mac;
    bit got, sv; int yv, chv, lat, seen;
    set_coeffs(16384, 16384, 0, -8192, 0);
    in_valid = 1; in_ch = 1; x = 1000;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL midmac_reset_outputs got rdy=%0b ov=%0b want 0 0", in_ready, out_valid); else passed++;
    rst_n = 1;
    model_clear();
    seen = 0;
    for (int i = 0; i < 2*N + 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midmac_no_output got %0d valid cycles want 0", seen); else passed++;
    send(0, 0, got, yv, sv, chv, lat);
    total++; if (!got || yv !== 0 || yv !== m_y) $display("FAIL midmac_history_zero got %0d want 0", yv); else passed++;
    finish_out();
  endtask

  task automatic test_random;
    bit got, sv; int yv, chv, lat, ch, xv;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0)
        set_coeffs(int'($urandom_range(32767)) - 16384, int'($urandom_range(32767)) - 16384,
                   int'($urandom_range(32767)) - 16384, int'($urandom_range(16383)) - 8192,
                   int'($urandom_range(16383)) - 8192);
      if ($urandom_range(9) == 0) pulse_clear();
      ch = int'($urandom_range(CH - 1));
      xv = int'($urandom_range(4095)) - 2048;
      send(ch, xv, got, yv, sv, chv, lat);
      total++; if (!got || yv !== m_y) $display("FAIL random_y%0d got %0d want %0d", i, yv, m_y); else passed++;
      total++; if (sv !== m_sat || chv !== ch) $display("FAIL random_sat_ch%0d got sat=%0b ch=%0d want sat=%0b ch=%0d", i, sv, chv, m_sat, ch); else passed++;
      repeat ($urandom_range(2)) @(negedge clk);
      finish_out();
    end
  endtask

  initial begin
    set_coeffs(0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    test_reset();
    test_identity();
    test_feedback();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_clear();
    test_bad_channel();
    test_random();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
